syn_weight_arbiter: RTL and testbench

Controller that owns the synapse weight BRAM: 32 words x 32 bits, holding four 8-bit weights per word (128 weights).
- Sequences the initial table load after reset or kill.
- Serves spike-driven weight reads.
- Performs STDP read-modify-write updates with saturation.
- Arbitrates reads against updates, with a starvation guard.
- Sits between the neuron/STDP logic and the byte-enabled synapse BRAM.

---
 rtl/syn_pkg.sv | 54 +++++
 rtl/syn_sat_update.sv | 13 +
 rtl/syn_weight_arbiter.sv | 179 +++++++++++++++++
 tb/tb_syn_weight_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_pkg.sv
// Shared types and helpers for the synapse weight BRAM controller.
package syn_pkg;

    localparam int unsigned WEIGHT_W     = 8;
    localparam int unsigned NUM_COL      = 4;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned NUM_WORDS    = 32;
    localparam int unsigned WADDR_W      = 7;
    localparam int unsigned MADDR_W      = 5;
    localparam int unsigned LANE_W       = 2;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned STARVE_W     = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_UP_RD = 2'd2,
        ST_UP_WR = 2'd3
    } state_t;

    // Byte write enable for a single weight lane.
    function automatic logic [NUM_COL-1:0] lane_we(input logic [LANE_W-1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [WEIGHT_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                      input logic [LANE_W-1:0] lane);
        case (lane)
            2'd0:    return word[WEIGHT_W-1:0];
            2'd1:    return word[2*WEIGHT_W-1:WEIGHT_W];
            2'd2:    return word[3*WEIGHT_W-1:2*WEIGHT_W];
            default: return word[4*WEIGHT_W-1:3*WEIGHT_W];
        endcase
    endfunction

    // Unsigned weight plus signed delta, clamped to [0, 255]; the 10-bit sum covers -128..382.
    function automatic logic [WEIGHT_W-1:0] sat_add(input logic [WEIGHT_W-1:0] old_w,
                                                    input logic [WEIGHT_W-1:0] delta);
        logic [WEIGHT_W+1:0] sum;
        sum = {2'b00, old_w} + {{2{delta[WEIGHT_W-1]}}, delta};
        if (sum[WEIGHT_W+1])
            return '0;
        else if (sum[WEIGHT_W])
            return '1;
        else
            return sum[WEIGHT_W-1:0];
    endfunction

endpackage

// File: rtl/syn_sat_update.sv
// Lane extract plus saturating STDP add on a raw BRAM word.
module syn_sat_update
    import syn_pkg::*;
(
    input  logic [WORD_W-1:0]   word,
    input  logic [LANE_W-1:0]   lane,
    input  logic [WEIGHT_W-1:0] delta,
    output logic [WEIGHT_W-1:0] new_weight_c
);

    assign new_weight_c = sat_add(lane_byte(word, lane), delta);

endmodule

// File: rtl/syn_weight_arbiter.sv
// Synapse weight BRAM owner: table load, spike reads, STDP read-modify-write with
// read-over-update arbitration and a starvation guard.
module syn_weight_arbiter
    import syn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                kill,
    input  logic                init_valid,
    input  logic [WORD_W-1:0]   init_data,
    output logic                init_ready,
    output logic                init_done,
    input  logic                rd_valid,
    input  logic [WADDR_W-1:0]  rd_addr,
    output logic                rd_ready,
    output logic                rd_rvalid,
    output logic [WEIGHT_W-1:0] rd_weight,
    input  logic                up_valid,
    input  logic [WADDR_W-1:0]  up_addr,
    input  logic [WEIGHT_W-1:0] up_delta,
    output logic                up_ready,
    output logic                mem_en,
    output logic [NUM_COL-1:0]  mem_we,
    output logic [MADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata
);

    state_t                state_q, state_d;
    logic [MADDR_W-1:0]    load_cnt_q, load_cnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  kill_pend_q, kill_pend_d;
    logic                  init_done_d;
    logic                  rd_rvalid_d;
    logic [LANE_W-1:0]     rd_lane_q, rd_lane_d;
    logic [LANE_W-1:0]     up_lane_q, up_lane_d;
    logic [MADDR_W-1:0]    up_word_q, up_word_d;
    logic [WEIGHT_W-1:0]   up_delta_q, up_delta_d;
    logic [WEIGHT_W-1:0]   new_q, new_d;
    logic [WEIGHT_W-1:0]   new_weight_c;
    logic                  kill_eff;
    logic                  up_force;

    syn_sat_update u_sat (
        .word         (mem_rdata),
        .lane         (up_lane_q),
        .delta        (up_delta_q),
        .new_weight_c (new_weight_c)
    );

    assign kill_eff = kill | kill_pend_q;
    assign up_force = (starve_q == STARVE_W'(STARVE_LIMIT));

    // BRAM data lands the cycle after accept, so the lane is the registered part.
    assign rd_weight = rd_rvalid ? lane_byte(mem_rdata, rd_lane_q) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            load_cnt_q  <= '0;
            starve_q    <= '0;
            kill_pend_q <= 1'b0;
            init_done   <= 1'b0;
            rd_rvalid   <= 1'b0;
            rd_lane_q   <= '0;
            up_lane_q   <= '0;
            up_word_q   <= '0;
            up_delta_q  <= '0;
            new_q       <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            starve_q    <= starve_d;
            kill_pend_q <= kill_pend_d;
            init_done   <= init_done_d;
            rd_rvalid   <= rd_rvalid_d;
            rd_lane_q   <= rd_lane_d;
            up_lane_q   <= up_lane_d;
            up_word_q   <= up_word_d;
            up_delta_q  <= up_delta_d;
            new_q       <= new_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        starve_d    = starve_q;
        kill_pend_d = kill_pend_q | kill;
        init_done_d = init_done;
        rd_rvalid_d = 1'b0;
        rd_lane_d   = rd_lane_q;
        up_lane_d   = up_lane_q;
        up_word_d   = up_word_q;
        up_delta_d  = up_delta_q;
        new_d       = new_q;
        init_ready  = 1'b0;
        rd_ready    = 1'b0;
        up_ready    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            ST_INIT: begin
                if (kill_eff) begin
                    load_cnt_d  = '0;
                    kill_pend_d = 1'b0;
                end else begin
                    init_ready = 1'b1;
                    if (init_valid) begin
                        mem_en     = 1'b1;
                        mem_we     = '1;
                        mem_addr   = load_cnt_q;
                        mem_wdata  = init_data;
                        load_cnt_d = load_cnt_q + MADDR_W'(1);
                        if (load_cnt_q == MADDR_W'(NUM_WORDS - 1)) begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                end
            end
            ST_IDLE: begin
                if (kill_eff) begin
                    state_d     = ST_INIT;
                    load_cnt_d  = '0;
                    init_done_d = 1'b0;
                    kill_pend_d = 1'b0;
                end else if (up_valid && (up_force || !rd_valid)) begin
                    up_ready   = 1'b1;
                    mem_en     = 1'b1;
                    mem_addr   = up_addr[WADDR_W-1:LANE_W];
                    up_word_d  = up_addr[WADDR_W-1:LANE_W];
                    up_lane_d  = up_addr[LANE_W-1:0];
                    up_delta_d = up_delta;
                    starve_d   = '0;
                    state_d    = ST_UP_RD;
                end else if (rd_valid) begin
                    rd_ready    = 1'b1;
                    mem_en      = 1'b1;
                    mem_addr    = rd_addr[WADDR_W-1:LANE_W];
                    rd_rvalid_d = 1'b1;
                    rd_lane_d   = rd_addr[LANE_W-1:0];
                    if (up_valid && !up_force)
                        starve_d = starve_q + STARVE_W'(1);
                end
            end
            ST_UP_RD: begin
                new_d   = new_weight_c;
                state_d = ST_UP_WR;
            end
            ST_UP_WR: begin
                mem_en    = 1'b1;
                mem_we    = lane_we(up_lane_q);
                mem_addr  = up_word_q;
                mem_wdata = {NUM_COL{new_q}};
                state_d   = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        if (!up_valid)
            starve_d = '0;

        // Nothing reaches the BRAM or the handshakes while reset is held.
        if (!rst) begin
            init_ready = 1'b0;
            rd_ready   = 1'b0;
            up_ready   = 1'b0;
            mem_en     = 1'b0;
            mem_we     = '0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

endmodule

// File: tb/tb_syn_weight_arbiter.sv
// Bench for syn_weight_arbiter: BRAM model plus a flat 128-entry weight reference.
module tb_syn_weight_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        kill;
    logic        init_valid;
    logic [31:0] init_data;
    logic        init_ready;
    logic        init_done;
    logic        rd_valid;
    logic [6:0]  rd_addr;
    logic        rd_ready;
    logic        rd_rvalid;
    logic [7:0]  rd_weight;
    logic        up_valid;
    logic [6:0]  up_addr;
    logic [7:0]  up_delta;
    logic        up_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] bram [32];
    int          ref_w [128];
    int          n_checks = 0;
    int          n_fail   = 0;

    syn_weight_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .init_valid (init_valid),
        .init_data  (init_data),
        .init_ready (init_ready),
        .init_done  (init_done),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_rvalid  (rd_rvalid),
        .rd_weight  (rd_weight),
        .up_valid   (up_valid),
        .up_addr    (up_addr),
        .up_delta   (up_delta),
        .up_ready   (up_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-enabled synchronous BRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we[0]) bram[mem_addr][7:0]   <= mem_wdata[7:0];
            if (mem_we[1]) bram[mem_addr][15:8]  <= mem_wdata[15:8];
            if (mem_we[2]) bram[mem_addr][23:16] <= mem_wdata[23:16];
            if (mem_we[3]) bram[mem_addr][31:24] <= mem_wdata[31:24];
            if (mem_we == 4'b0000) mem_rdata <= bram[mem_addr];
        end
    end

    function automatic int clamp_add(input int old_w, input logic [7:0] delta);
        int s;
        s = old_w + int'($signed(delta));
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b0; kill = 1'b0; init_valid = 1'b1; init_data = $urandom;
        rd_valid = 1'b1; rd_addr = 7'h11; up_valid = 1'b1; up_addr = 7'h22; up_delta = 8'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({init_ready, init_done, rd_ready, rd_rvalid, up_ready, mem_en} !== 6'b0 ||
            mem_we !== 4'h0 || mem_addr !== 5'h0 || mem_wdata !== 32'h0 || rd_weight !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ir=%b id=%b rr=%b rv=%b ur=%b en=%b we=%h a=%h wd=%h w=%h, want all 0",
                     init_ready, init_done, rd_ready, rd_rvalid, up_ready, mem_en, mem_we, mem_addr,
                     mem_wdata, rd_weight);
        end
        init_valid = 1'b0; rd_valid = 1'b0; up_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_table(input bit pattern);
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            if (pattern) d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            else         d = $urandom;
            init_valid = 1'b1; init_data = d;
            @(negedge clk);
            n_checks++;
            if (init_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'hF ||
                mem_addr !== 5'(i) || mem_wdata !== d || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL init_word%0d: ready=%b en=%b we=%h addr=%0d wdata=%h done=%b, want 1 1 f %0d %h 0",
                         i, init_ready, mem_en, mem_we, mem_addr, mem_wdata, init_done, i, d);
            end
            for (int b = 0; b < 4; b++) ref_w[4*i+b] = int'(d[8*b +: 8]);
            @(posedge clk); #1;
        end
        init_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || init_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done: done=%b ready=%b, want done=1 ready=0", init_done, init_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_reads(input int n, input logic [6:0] base, input bit rnd);
        logic [6:0] a;
        logic [6:0] pa;
        bit         pend;
        pend = 1'b0; pa = '0; a = '0;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                a = rnd ? 7'($urandom_range(0, 127)) : 7'(base + 7'(k));
                rd_valid = 1'b1; rd_addr = a;
            end else begin
                rd_valid = 1'b0;
            end
            @(negedge clk);
            if (k < n) begin
                n_checks++;
                if (rd_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== a[6:2]) begin
                    n_fail++;
                    $display("FAIL read_accept a=%h: ready=%b en=%b we=%h addr=%h, want 1 1 0 %h",
                             a, rd_ready, mem_en, mem_we, mem_addr, a[6:2]);
                end
            end
            n_checks++;
            if (rd_rvalid !== pend || (pend && rd_weight !== 8'(ref_w[pa]))) begin
                n_fail++;
                $display("FAIL read_data a=%h: rvalid=%b weight=%h, want rvalid=%b weight=%h",
                         pa, rd_rvalid, rd_weight, pend, 8'(ref_w[pa]));
            end
            pend = (k < n); pa = a;
            @(posedge clk); #1;
        end
    endtask

    task automatic up_one(input logic [6:0] a, input logic [7:0] delta);
        int         nv;
        logic [3:0] we_exp;
        nv = clamp_add(ref_w[a], delta);
        we_exp = 4'(1 << a[1:0]);
        rd_valid = 1'b0; up_valid = 1'b1; up_addr = a; up_delta = delta;
        @(negedge clk);
        n_checks++;
        if (up_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== a[6:2]) begin
            n_fail++;
            $display("FAIL up_accept a=%h: ready=%b en=%b we=%h addr=%h, want 1 1 0 %h",
                     a, up_ready, mem_en, mem_we, mem_addr, a[6:2]);
        end
        @(posedge clk); #1;
        up_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0 || rd_ready !== 1'b0 || up_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL up_rd_idle a=%h: en=%b rr=%b ur=%b, want 0 0 0", a, mem_en, rd_ready, up_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_we !== we_exp || mem_addr !== a[6:2] ||
            mem_wdata[8*a[1:0] +: 8] !== 8'(nv)) begin
            n_fail++;
            $display("FAIL up_write a=%h d=%h: en=%b we=%h addr=%h byte=%h, want 1 %h %h %h",
                     a, delta, mem_en, mem_we, mem_addr, mem_wdata[8*a[1:0] +: 8], we_exp, a[6:2], 8'(nv));
        end
        ref_w[a] = nv;
        @(posedge clk); #1;
    endtask

    task automatic test_init_load();
        load_table(1'b1);
        run_reads(1, 7'h29, 1'b0);
    endtask

    task automatic test_pipelined_reads();
        run_reads(4, 7'h00, 1'b0);
        run_reads(16, 7'h00, 1'b1);
    endtask

    task automatic test_saturation();
        logic [6:0] a;
        up_one(7'd5, 8'h7F);
        up_one(7'd5, 8'h7F);
        up_one(7'd6, 8'h80);
        up_one(7'd7, 8'hE0);
        run_reads(4, 7'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            a = 7'($urandom_range(0, 127));
            up_one(a, 8'($urandom));
            run_reads(4, {a[6:2], 2'b00}, 1'b0);
        end
    endtask

    task automatic test_starvation();
        logic [6:0] ua, ra, pa;
        logic [7:0] ud;
        bit         pend, exp_rd, exp_up;
        ua = 7'($urandom_range(0, 127)); ud = 8'($urandom);
        up_valid = 1'b1; up_addr = ua; up_delta = ud;
        pend = 1'b0; pa = '0;
        for (int k = 0; k <= 8; k++) begin
            ra = 7'($urandom_range(0, 127));
            rd_valid = (k < 8); rd_addr = ra;
            exp_rd = (k < 4) || (k == 7);
            exp_up = (k == 4);
            @(negedge clk);
            n_checks++;
            if (rd_ready !== exp_rd || up_ready !== exp_up) begin
                n_fail++;
                $display("FAIL starve_cycle%0d: rd_ready=%b up_ready=%b, want %b %b",
                         k, rd_ready, up_ready, exp_rd, exp_up);
            end
            n_checks++;
            if (rd_rvalid !== pend || (pend && rd_weight !== 8'(ref_w[pa]))) begin
                n_fail++;
                $display("FAIL starve_read%0d a=%h: rvalid=%b weight=%h, want %b %h",
                         k, pa, rd_rvalid, rd_weight, pend, 8'(ref_w[pa]));
            end
            if (k == 6) begin
                n_checks++;
                if (mem_we !== 4'(1 << ua[1:0]) || mem_addr !== ua[6:2]) begin
                    n_fail++;
                    $display("FAIL starve_write: we=%h addr=%h, want %h %h",
                             mem_we, mem_addr, 4'(1 << ua[1:0]), ua[6:2]);
                end
                ref_w[ua] = clamp_add(ref_w[ua], ud);
            end
            pend = exp_rd; pa = ra;
            @(posedge clk); #1;
            if (k == 4) up_valid = 1'b0;
        end
        rd_valid = 1'b0;
        run_reads(4, {ua[6:2], 2'b00}, 1'b0);
    endtask

    task automatic test_kill_mid_update();
        logic [6:0] a;
        logic [7:0] d;
        int         nv;
        a = 7'($urandom_range(0, 127)); d = 8'($urandom);
        nv = clamp_add(ref_w[a], d);
        up_valid = 1'b1; up_addr = a; up_delta = d;
        @(posedge clk); #1;
        up_valid = 1'b0; kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_we !== 4'(1 << a[1:0]) || mem_wdata[8*a[1:0] +: 8] !== 8'(nv)) begin
            n_fail++;
            $display("FAIL kill_write: en=%b we=%h byte=%h, want 1 %h %h",
                     mem_en, mem_we, mem_wdata[8*a[1:0] +: 8], 4'(1 << a[1:0]), 8'(nv));
        end
        @(posedge clk); #1;
        rd_valid = 1'b1; rd_addr = 7'($urandom_range(0, 127));
        @(negedge clk);
        n_checks++;
        if (rd_ready !== 1'b0 || mem_en !== 1'b0 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_block: rd_ready=%b en=%b done=%b, want 0 0 1", rd_ready, mem_en, init_done);
        end
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b0 || init_ready !== 1'b1 || rd_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_init: done=%b ready=%b rvalid=%b, want 0 1 0", init_done, init_ready, rd_rvalid);
        end
        @(posedge clk); #1;
        load_table(1'b0);
        run_reads(12, 7'h00, 1'b1);
    endtask

    task automatic test_reset_mid_init();
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        for (int i = 0; i < 10; i++) begin
            init_valid = 1'b1; init_data = $urandom;
            @(negedge clk);
            n_checks++;
            if (mem_addr !== 5'(i) || mem_en !== 1'b1) begin
                n_fail++;
                $display("FAIL partial_load%0d: addr=%0d en=%b, want %0d 1", i, mem_addr, mem_en, i);
            end
            @(posedge clk); #1;
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({init_ready, init_done, rd_rvalid, up_ready, rd_ready, mem_en} !== 6'b0 ||
            mem_we !== 4'h0 || mem_addr !== 5'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: ir=%b id=%b rv=%b ur=%b rr=%b en=%b we=%h a=%h wd=%h, want all 0",
                     init_ready, init_done, rd_rvalid, up_ready, rd_ready, mem_en, mem_we, mem_addr, mem_wdata);
        end
        init_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        load_table(1'b0);
        run_reads(32, 7'h00, 1'b0);
        run_reads(12, 7'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init_load();
        test_pipelined_reads();
        test_saturation();
        test_starvation();
        test_kill_mid_update();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
